// File: rtl/opb_swreg_bank_ctrl.sv
// opb_swreg_bank_ctrl: OPB slave fronting a bank of C_NUM_REGS software-writable 32-bit registers.
// The OPB big-endian buses are carried as descending [31:0] vectors with identical bit patterns:
// OPB bit 0 (MSB) is index 31 here, so OPB_BE[3] enables OPB_DBus[31:24] (OPB byte lane 0).
// Optional feature macro: OPB_SWREG_READBACK_EN -- when defined, reads return the register
// contents; when undefined, valid reads are acked with zero data and no readback mux exists.
module opb_swreg_bank_ctrl #(
  parameter logic [31:0] C_BASEADDR    = 32'h01001200,
  parameter logic [31:0] C_HIGHADDR    = 32'h010012FF,
  parameter int unsigned C_NUM_REGS    = 4,
  parameter int unsigned C_ACK_LATENCY = 2
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [31:0]              OPB_ABus,
  input  logic [3:0]               OPB_BE,
  input  logic [31:0]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [31:0]              Sl_DBus,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic                     Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0] reg_data_out,
  output logic [C_NUM_REGS-1:0]    reg_update
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(C_ACK_LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [DATA_W-1:0]  data_q;
  logic               rnw_q;
  logic [DATA_W-1:0]  regs_q [C_NUM_REGS];

  logic               hit_c;
  logic [31:0]        tgt_addr_c;
  logic               tgt_valid_c;
  logic [DATA_W-1:0]  rdata_c;
  logic               wr_valid_c;
  logic [IDX_W-1:0]   wr_idx_c;
  logic [DATA_W-1:0]  wr_mask_c;
`ifdef OPB_SWREG_READBACK_EN
  logic               tgt_rnw_c;
`endif

  // Address falls inside the window and maps to an implemented register
  function automatic logic addr_valid(input logic [31:0] a);
    logic [31:0] off;
    off = a - C_BASEADDR;
    return (a >= C_BASEADDR) && (a <= C_HIGHADDR) && ((off >> 2) < 32'(C_NUM_REGS));
  endfunction

  // Word index of an address relative to the window base (low two bits ignored)
  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - C_BASEADDR;
    return IDX_W'(off >> 2);
  endfunction

  assign Sl_retry = 1'b0;

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign reg_data_out[32*k +: 32] = regs_q[k];
  end

  // Decode of the beat about to be acked and of the beat currently in its ack cycle
  always_comb begin
    hit_c      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    tgt_addr_c = addr_q;
`ifdef OPB_SWREG_READBACK_EN
    tgt_rnw_c  = rnw_q;
`endif
    if (state_q == ST_IDLE) begin
      tgt_addr_c = OPB_ABus;
`ifdef OPB_SWREG_READBACK_EN
      tgt_rnw_c  = OPB_RNW;
`endif
    end else if (state_q == ST_ACK) begin
      tgt_addr_c = addr_q + 32'd4;
`ifdef OPB_SWREG_READBACK_EN
      tgt_rnw_c  = OPB_RNW;
`endif
    end
    tgt_valid_c = addr_valid(tgt_addr_c);
    rdata_c     = '0;
`ifdef OPB_SWREG_READBACK_EN
    if (tgt_valid_c && tgt_rnw_c) rdata_c = regs_q[addr_idx(tgt_addr_c)];
`endif
    wr_valid_c = addr_valid(addr_q);
    wr_idx_c   = addr_idx(addr_q);
    wr_mask_c  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  end

  // Transaction FSM, register bank and registered bus/user outputs
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      data_q     <= '0;
      rnw_q      <= 1'b0;
      for (int unsigned k = 0; k < C_NUM_REGS; k++) regs_q[k] <= '0;
      Sl_DBus    <= '0;
      Sl_errAck  <= 1'b0;
      Sl_toutSup <= 1'b0;
      Sl_xferAck <= 1'b0;
      reg_update <= '0;
    end else begin
      Sl_DBus    <= '0;
      Sl_errAck  <= 1'b0;
      Sl_toutSup <= 1'b0;
      Sl_xferAck <= 1'b0;
      reg_update <= '0;
      case (state_q)
        ST_IDLE: begin
          if (hit_c) begin
            addr_q <= OPB_ABus;
            be_q   <= OPB_BE;
            data_q <= OPB_DBus;
            rnw_q  <= OPB_RNW;
            cnt_q  <= CNT_INIT;
            if (C_ACK_LATENCY == 1) begin
              state_q    <= ST_ACK;
              Sl_xferAck <= 1'b1;
              Sl_errAck  <= ~tgt_valid_c;
              Sl_DBus    <= rdata_c;
            end else begin
              state_q    <= ST_WAIT;
              Sl_toutSup <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!OPB_select) begin
            state_q <= ST_IDLE;
          end else if (cnt_q <= CNT_W'(1)) begin
            cnt_q      <= '0;
            state_q    <= ST_ACK;
            Sl_xferAck <= 1'b1;
            Sl_errAck  <= ~tgt_valid_c;
            Sl_DBus    <= rdata_c;
          end else begin
            cnt_q      <= cnt_q - CNT_W'(1);
            Sl_toutSup <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!rnw_q && wr_valid_c) begin
            regs_q[wr_idx_c]     <= (regs_q[wr_idx_c] & ~wr_mask_c) | (data_q & wr_mask_c);
            reg_update[wr_idx_c] <= 1'b1;
          end
          if (OPB_select && OPB_seqAddr) begin
            addr_q <= addr_q + 32'd4;
            be_q   <= OPB_BE;
            data_q <= OPB_DBus;
            rnw_q  <= OPB_RNW;
            cnt_q  <= CNT_INIT;
            if (C_ACK_LATENCY == 1) begin
              state_q    <= ST_ACK;
              Sl_xferAck <= 1'b1;
              Sl_errAck  <= ~tgt_valid_c;
              Sl_DBus    <= rdata_c;
            end else begin
              state_q    <= ST_WAIT;
              Sl_toutSup <= 1'b1;
            end
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!OPB_select) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opb_swreg_bank_ctrl.sv
// tb_opb_swreg_bank_ctrl: scoreboard bench for the OPB software register bank.
// Expected ack results are queued as each beat is driven and popped on Sl_xferAck.
module tb_opb_swreg_bank_ctrl;

  localparam logic [31:0] BASE  = 32'h01001200;
  localparam logic [31:0] HIGH  = 32'h010012FF;
  localparam int unsigned NREGS = 4;
  localparam int unsigned LAT   = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         OPB_Rst;
  logic [31:0]  OPB_ABus;
  logic [3:0]   OPB_BE;
  logic [31:0]  OPB_DBus;
  logic         OPB_RNW;
  logic         OPB_select;
  logic         OPB_seqAddr;
  logic [31:0]  Sl_DBus;
  logic         Sl_errAck;
  logic         Sl_retry;
  logic         Sl_toutSup;
  logic         Sl_xferAck;
  logic [127:0] reg_data_out;
  logic [3:0]   reg_update;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model [NREGS];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  opb_swreg_bank_ctrl #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_NUM_REGS   (NREGS),
    .C_ACK_LATENCY(LAT)
  ) dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (OPB_Rst),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .Sl_xferAck  (Sl_xferAck),
    .reg_data_out(reg_data_out),
    .reg_update  (reg_update)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [31:0] a, input logic rnw,
                       input logic [3:0] be, input logic [31:0] d, input logic seq);
    OPB_select  = sel;
    OPB_ABus    = a;
    OPB_RNW     = rnw;
    OPB_BE      = be;
    OPB_DBus    = d;
    OPB_seqAddr = seq;
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >= BASE) && (a <= HIGH) && (((a - BASE) / 4) < NREGS);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] readback(input int idx);
`ifdef OPB_SWREG_READBACK_EN
    return model[idx];
`else
    return (idx < 0) ? 32'hFFFFFFFF : 32'h0;
`endif
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int k = 0; k < int'(NREGS); k++) f[32*k +: 32] = model[k];
    return f;
  endfunction

  // OPB lane b (0 = MSB byte) is enabled by BE bit (3-b) of the descending vector
  task automatic model_write(input int idx, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[3-b]) model[idx][31-8*b -: 8] = d[31-8*b -: 8];
  endtask

  task automatic push_exp(input logic [31:0] a, input logic rnw);
    exp_t e;
    e.err  = !addr_ok(a);
    e.data = '0;
    if (addr_ok(a) && rnw) e.data = readback(idx_of(a));
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!Sl_xferAck && lat < 20);
    if (!Sl_xferAck) check("ack_timeout", 128'(0), 128'(1));
  endtask

  task automatic single(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                        input logic [31:0] d);
    int         lat;
    logic [3:0] upd;
    push_exp(a, rnw);
    drive(1'b1, a, rnw, be, d, 1'b0);
    wait_ack(lat);
    check("ack_latency", 128'(lat), 128'(LAT));
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    upd = '0;
    if (addr_ok(a) && !rnw) begin
      model_write(idx_of(a), be, d);
      upd = 4'(1) << idx_of(a);
    end
    step();
    check("single_regs", reg_data_out, model_flat());
    check("single_update", 128'(reg_update), 128'(upd));
    step();
    check("single_update_clear", 128'(reg_update), 128'(0));
  endtask

  task automatic burst(input logic [31:0] start, input int nbeats, input logic [31:0] dbase);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  upd;
    int          lat;
    a = start;
    d = dbase;
    push_exp(a, 1'b0);
    drive(1'b1, a, 1'b0, 4'hF, d, 1'b1);
    for (int beat = 0; beat < nbeats; beat++) begin
      wait_ack(lat);
      upd = '0;
      if (addr_ok(a)) begin
        model_write(idx_of(a), 4'hF, d);
        upd = 4'(1) << idx_of(a);
      end
      if (beat < nbeats - 1) begin
        a = a + 32'd4;
        d = d + 32'h01010101;
        push_exp(a, 1'b0);
        drive(1'b1, a, 1'b0, 4'hF, d, 1'b1);
      end else begin
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      end
      step();
      check("burst_update", 128'(reg_update), 128'(upd));
      check("burst_regs", reg_data_out, model_flat());
    end
    step();
    check("burst_update_clear", 128'(reg_update), 128'(0));
  endtask

  // Ack monitor: pops the scoreboard on every ack and polices idle-cycle outputs
  always @(negedge clk) begin
    if (mon_en) begin
      check("retry_zero", 128'(Sl_retry), 128'(0));
      check("update_onehot", 128'($countones(reg_update) <= 1), 128'(1));
      if (Sl_xferAck) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 128'(1), 128'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("ack_err", 128'(Sl_errAck), 128'(mon_e.err));
          check("ack_data", 128'(Sl_DBus), 128'(mon_e.data));
        end
      end else begin
        check("idle_bus", 128'({Sl_errAck, Sl_DBus}), 128'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acks;
    for (int k = 0; k < int'(NREGS); k++) model[k] = '0;
    OPB_Rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (3) step();
    check("reset_outputs", 128'({Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck, reg_update}),
          128'(0));
    check("reset_regs", reg_data_out, 128'(0));
    OPB_Rst = 1'b0;
    mon_en  = 1'b1;
    step();

    // Full-word write, byte-lane write, then readback
    single(BASE + 32'h4, 1'b0, 4'b1111, 32'hDEADBEEF);
    check("reg1_deadbeef", 128'(reg_data_out[63:32]), 128'(32'hDEADBEEF));
    single(BASE + 32'h4, 1'b0, 4'b0001, 32'h00000011);
    check("reg1_byte_lane", 128'(reg_data_out[63:32]), 128'(32'hDEADBE11));
    single(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);
    single(BASE + 32'hC, 1'b0, 4'b1010, 32'hA1B2C3D4);

    // Select held high on a single read: one ack, toutSup only while waiting
    push_exp(BASE + 32'h4, 1'b1);
    drive(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1'b0);
    acks = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (Sl_xferAck) acks++;
      check("hold_tout_sup", 128'(Sl_toutSup), 128'(i == 1));
    end
    check("hold_ack_count", 128'(acks), 128'(1));
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) step();

    // Valid window, unimplemented register
    single(BASE + 32'h40, 1'b0, 4'hF, 32'hFFFFFFFF);

    // Sequential bursts: in-range, then one that runs off the window
    burst(BASE + 32'h4, 3, 32'h11223344);
    burst(HIGH - 32'h3, 2, 32'h99999999);

    // Master abort while waiting: no ack, no write
    drive(1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'h55AA55AA, 1'b0);
    step();
    check("abort_tout_sup", 128'(Sl_toutSup), 128'(1));
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    repeat (4) begin
      step();
      check("abort_no_ack", 128'(Sl_xferAck), 128'(0));
      check("abort_update", 128'(reg_update), 128'(0));
    end
    check("abort_regs", reg_data_out, model_flat());

    // Reset during the wait of a write to reg0
    single(BASE, 1'b0, 4'hF, 32'hCAFEF00D);
    drive(1'b1, BASE, 1'b0, 4'hF, 32'h12345678, 1'b0);
    step();
    check("rst_wait_tout", 128'(Sl_toutSup), 128'(1));
    OPB_Rst = 1'b1;
    step();
    for (int k = 0; k < int'(NREGS); k++) model[k] = '0;
    check("rst_wait_outputs",
          128'({Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck, reg_update}), 128'(0));
    check("rst_wait_regs", reg_data_out, 128'(0));
    OPB_Rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    step();
    single(BASE, 1'b1, 4'hF, 32'h0);
    single(BASE + 32'h8, 1'b0, 4'b0110, 32'h0BADF00D);

    repeat (2) step();
    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
